inst_fetch_responder: RTL and testbench

- Instruction-side memory responder for the npc core: the core issues a fetch address (pc), and this block returns the 32-bit instruction.
- Word-addressed instruction ROM/RAM with a simulation/boot load port and a configurable fixed access latency.
- valid/ready handshakes on both the request and response channels; at most one outstanding fetch.
- Flags misaligned and out-of-range fetches, and keeps a count of completed fetches.

---
 rtl/inst_fetch_responder.sv | 129 ++++++++++++
 tb/tb_inst_fetch_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_responder.sv
// Instruction-side memory responder: word-addressed instruction store with a boot load port,
// fixed access latency, one outstanding fetch, and fault flagging for bad fetch addresses.
module inst_fetch_responder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
   parameter int          LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [63:0]           req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_inst,
   output logic                  rsp_err,
   input  logic                  ld_en,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [31:0]           ld_data,
   output logic [31:0]           fetch_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   logic [31:0] mem [DEPTH];

   state_t      state_q,     state_d;
   logic [63:0] addr_q,      addr_d;
   logic [3:0]  lat_cnt_q,   lat_cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_inst_q,  rsp_inst_d;
   logic        rsp_err_q,   rsp_err_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   logic [63:0]           cap_addr;
   logic [61:0]           off_w;
   logic [DEPTH_LOG2-1:0] cap_idx;
   logic                  cap_fault;
   logic [31:0]           cap_word;

   // With single-cycle latency the capture edge is the acceptance edge, so decode the live address.
   always_comb begin
      cap_addr  = (LATENCY == 1) ? req_addr : addr_q;
      off_w     = cap_addr[63:2] - BASE[63:2];
      cap_idx   = off_w[DEPTH_LOG2-1:0];
      cap_fault = (cap_addr[1:0] != 2'b00) || (cap_addr < BASE) ||
                  (off_w[61:DEPTH_LOG2] != '0);
      cap_word  = cap_fault ? 32'h0000_0000 : mem[cap_idx];
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      lat_cnt_d   = lat_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_inst_d  = rsp_inst_q;
      rsp_err_d   = rsp_err_q;
      fetch_cnt_d = fetch_cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr;
               lat_cnt_d = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  rsp_inst_d  = cap_word;
                  rsp_err_d   = cap_fault;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            lat_cnt_d = lat_cnt_q - 4'd1;
            if (lat_cnt_q == 4'd1) begin
               rsp_inst_d  = cap_word;
               rsp_err_d   = cap_fault;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               fetch_cnt_d = fetch_cnt_q + 32'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         lat_cnt_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_inst_q  <= '0;
         rsp_err_q   <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         lat_cnt_q   <= lat_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_inst_q  <= rsp_inst_d;
         rsp_err_q   <= rsp_err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   // Storage is not reset; a write landing on the capture edge leaves the old word in rsp_inst.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

   assign req_ready = rst && (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_inst  = rsp_inst_q;
   assign rsp_err   = rsp_err_q;
   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench: a LATENCY=2 instance for directed fetch/fault/collision/reset cases and a
// LATENCY=1 instance for back-to-back throughput.
module tb_inst_fetch_responder;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
   localparam int LAT0 = 2;

   typedef struct packed {
      logic [31:0] inst;
      logic        err;
      logic [31:0] due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic        rst0, req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0, ld_en0;
   logic [63:0] req_addr0;
   logic [31:0] rsp_inst0, ld_data0, fetch_cnt0;
   logic [9:0]  ld_addr0;

   logic        rst1, req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1, ld_en1;
   logic [63:0] req_addr1;
   logic [31:0] rsp_inst1, ld_data1, fetch_cnt1;
   logic [9:0]  ld_addr1;

   inst_fetch_responder #(.DEPTH_LOG2(10), .BASE(BASE), .LATENCY(LAT0)) dut0 (
      .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_addr(req_addr0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
      .rsp_inst(rsp_inst0), .rsp_err(rsp_err0), .ld_en(ld_en0), .ld_addr(ld_addr0),
      .ld_data(ld_data0), .fetch_cnt(fetch_cnt0)
   );

   inst_fetch_responder #(.DEPTH_LOG2(10), .BASE(BASE), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_addr(req_addr1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_inst(rsp_inst1), .rsp_err(rsp_err1), .ld_en(ld_en1), .ld_addr(ld_addr1),
      .ld_data(ld_data1), .fetch_cnt(fetch_cnt1)
   );

   exp_t q0[$];
   exp_t q1[$];
   logic seen0 = 1'b0;
   logic seen1 = 1'b0;
   int   exp_cnt0 = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitors: every presented response is compared against the head of its queue.
   always @(negedge clk) begin
      if (rsp_valid0) begin
         if (q0.size() == 0) begin
            chk("rsp0_unexpected", rsp_valid0, 0);
         end else begin
            if (!seen0) begin
               chk("rsp0_latency", 64'(cyc), 64'(q0[0].due));
               seen0 = 1'b1;
            end
            chk("rsp0_inst", rsp_inst0, q0[0].inst);
            chk("rsp0_err", rsp_err0, q0[0].err);
            if (rsp_ready0) begin
               void'(q0.pop_front());
               seen0 = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rsp_valid1) begin
         if (q1.size() == 0) begin
            chk("rsp1_unexpected", rsp_valid1, 0);
         end else begin
            if (!seen1) begin
               chk("rsp1_latency", 64'(cyc), 64'(q1[0].due));
               seen1 = 1'b1;
            end
            chk("rsp1_inst", rsp_inst1, q1[0].inst);
            chk("rsp1_err", rsp_err1, q1[0].err);
            if (rsp_ready1) begin
               void'(q1.pop_front());
               seen1 = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load0(input int idx, input logic [31:0] d);
      ld_en0 = 1'b1; ld_addr0 = 10'(idx); ld_data0 = d;
      tick();
      ld_en0 = 1'b0;
   endtask

   task automatic load1(input int idx, input logic [31:0] d);
      ld_en1 = 1'b1; ld_addr1 = 10'(idx); ld_data1 = d;
      tick();
      ld_en1 = 1'b0;
   endtask

   // hold: cycles of rsp_ready=0 after rsp_valid; bp_ld writes during the hold,
   // col_ld writes on the capture edge.
   task automatic fetch0(input logic [63:0] a, input logic [31:0] ei, input logic ee,
                         input int hold, input logic bp_ld, input logic col_ld,
                         input int ld_idx, input logic [31:0] ld_d);
      int n;
      n = 0;
      while (!req_ready0 && n < 20) begin tick(); n++; end
      chk("req_ready_idle", req_ready0, 1);
      q0.push_back('{inst: ei, err: ee, due: 32'(cyc + LAT0)});
      req_valid0 = 1'b1; req_addr0 = a; rsp_ready0 = 1'b0;
      tick();
      req_valid0 = 1'b0; req_addr0 = ~a;
      if (col_ld) begin ld_en0 = 1'b1; ld_addr0 = 10'(ld_idx); ld_data0 = ld_d; end
      n = 0;
      while (!rsp_valid0 && n < 20) begin tick(); ld_en0 = 1'b0; n++; end
      ld_en0 = 1'b0;
      chk("rsp_valid_timeout", rsp_valid0, 1);
      for (int i = 0; i < hold; i++) begin
         chk("req_ready_bp", req_ready0, 0);
         chk("fetch_cnt_bp", fetch_cnt0, 32'(exp_cnt0));
         if (bp_ld && i == 1) begin
            ld_en0 = 1'b1; ld_addr0 = 10'(ld_idx); ld_data0 = ld_d;
         end else begin
            ld_en0 = 1'b0;
         end
         tick();
      end
      ld_en0 = 1'b0;
      rsp_ready0 = 1'b1;
      tick();
      rsp_ready0 = 1'b0;
      exp_cnt0++;
      chk("fetch_cnt", fetch_cnt0, 32'(exp_cnt0));
      chk("req_ready_after_rsp", req_ready0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst0 = 1'b0; req_valid0 = 1'b0; req_addr0 = '0; rsp_ready0 = 1'b0;
      ld_en0 = 1'b0; ld_addr0 = '0; ld_data0 = '0;
      rst1 = 1'b0; req_valid1 = 1'b0; req_addr1 = '0; rsp_ready1 = 1'b0;
      ld_en1 = 1'b0; ld_addr1 = '0; ld_data1 = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready0", req_ready0, 0);
      chk("reset_rsp_valid0", rsp_valid0, 0);
      chk("reset_rsp_inst0", rsp_inst0, 0);
      chk("reset_rsp_err0", rsp_err0, 0);
      chk("reset_fetch_cnt0", fetch_cnt0, 0);
      chk("reset_req_ready1", req_ready1, 0);
      chk("reset_fetch_cnt1", fetch_cnt1, 0);
      tick();
      rst0 = 1'b1; rst1 = 1'b1;

      load0(0, 32'h0000_0513);
      load0(1, 32'h0010_0073);
      load0(3, 32'h2222_2222);
      load0(1023, 32'hCAFE_F00D);

      fetch0(BASE,           32'h0000_0513, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
      fetch0(BASE + 64'h4,   32'h0010_0073, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
      fetch0(BASE,           32'h0000_0513, 1'b0, 5, 1'b1, 1'b0, 0, 32'hDEAD_BEEF);
      fetch0(BASE,           32'hDEAD_BEEF, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
      fetch0(BASE + 64'h2,   32'h0000_0000, 1'b1, 0, 1'b0, 1'b0, 0, 32'h0);
      fetch0(BASE + 64'h1000, 32'h0000_0000, 1'b1, 0, 1'b0, 1'b0, 0, 32'h0);
      fetch0(64'h0000_0000_7FFF_FFFC, 32'h0000_0000, 1'b1, 0, 1'b0, 1'b0, 0, 32'h0);
      fetch0(BASE + 64'hFFC, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
      fetch0(BASE + 64'hC,   32'h2222_2222, 1'b0, 0, 1'b0, 1'b1, 3, 32'h1111_1111);
      fetch0(BASE + 64'hC,   32'h1111_1111, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);

      // Reset during WAIT: no response may follow.
      req_valid0 = 1'b1; req_addr0 = BASE;
      tick();
      req_valid0 = 1'b0;
      rst0 = 1'b0;
      #1;
      chk("midrst_rsp_valid", rsp_valid0, 0);
      chk("midrst_fetch_cnt", fetch_cnt0, 0);
      chk("midrst_req_ready", req_ready0, 0);
      chk("midrst_rsp_inst", rsp_inst0, 0);
      exp_cnt0 = 0;
      tick(); tick();
      rst0 = 1'b1;
      #2;
      chk("postrst_req_ready", req_ready0, 1);
      rsp_ready0 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("postrst_no_rsp", rsp_valid0, 0);
      end
      rsp_ready0 = 1'b0;
      fetch0(BASE + 64'h4,   32'h0010_0073, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);

      // LATENCY=1 instance: 100 back-to-back fetches.
      for (int i = 0; i < 100; i++) load1(i, 32'h1000_0000 + 32'(i));
      rsp_ready1 = 1'b1;
      req_valid1 = 1'b1;
      k = 0;
      for (int j = 0; j < 200; j++) begin
         if (req_ready1 && k < 100) begin
            req_addr1 = BASE + 64'(4 * k);
            q1.push_back('{inst: 32'h1000_0000 + 32'(k), err: 1'b0, due: 32'(cyc + 1)});
            k++;
         end
         tick();
      end
      req_valid1 = 1'b0;
      chk("lat1_fetch_cnt_200", fetch_cnt1, 100);
      chk("lat1_queue_drained", 64'(q1.size()), 0);
      chk("lat0_queue_drained", 64'(q0.size()), 0);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
